// File: rtl/key_expansion_pkg.sv
// rtl/key_expansion_pkg.sv - AES-128 key schedule constants and helpers
package key_expansion_pkg;

    localparam int NK      = 4;
    localparam int NR      = 10;
    localparam int NW      = 44;
    localparam int KEY_W   = 128;
    localparam int SCHED_W = 1408;

    // Round constants for rounds 1..10, stored at indices 0..9
    localparam logic [7:0] RCON [NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Cyclic left rotation by one byte: {a0,a1,a2,a3} -> {a1,a2,a3,a0}
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_expansion_sbox.sv
// rtl/key_expansion_sbox.sv - combinational AES forward S-box (module aes_sbox)
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry n lives at bits [2047-8n -: 8], so entry 0 is the leftmost byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base;

    // Byte lookup into the flattened table
    always_comb begin
        base     = 11'd2047 - {in_byte, 3'b000};
        out_byte = SBOX_TABLE[base -: 8];
    end

endmodule

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - AES-128 key schedule, combinational expansion with one output register
module key_expansion
    import key_expansion_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [KEY_W-1:0]     i_cypher_key,
    output logic [SCHED_W-1:0]   o_expanded_key
);

    logic [SCHED_W-1:0] sched;

    // Each word lives in its own generate scope so later words chain from earlier ones
    for (genvar i = 0; i < NW; i++) begin : g_word
        logic [31:0] word;

        if (i < NK) begin : g_key
            assign word = i_cypher_key[KEY_W-1-32*i -: 32];
        end else if (i % NK == 0) begin : g_rot
            logic [31:0] rot;
            logic [31:0] sub;
            assign rot = rot_word(g_word[i-1].word);
            for (genvar b = 0; b < 4; b++) begin : g_sbox
                aes_sbox u_sbox (
                    .in_byte  (rot[8*b +: 8]),
                    .out_byte (sub[8*b +: 8])
                );
            end
            assign word = g_word[i-NK].word ^ sub ^ {RCON[i/NK-1], 24'h000000};
        end else begin : g_xor
            assign word = g_word[i-NK].word ^ g_word[i-1].word;
        end

        assign sched[SCHED_W-1-32*i -: 32] = word;
    end

    // Capture the full schedule every edge; reset wins over capture
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_expanded_key <= '0;
        end else begin
            o_expanded_key <= sched;
        end
    end

endmodule

// File: tb/tb_key_expansion.sv
// tb/tb_key_expansion.sv - self-checking bench for key_expansion
module tb_key_expansion;

    logic          clk;
    logic          rst_n;
    logic [127:0]  key;
    logic [1407:0] out;

    int checks;
    int failures;

    logic [7:0] sbox_ref [256];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY  = 128'h0;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_expansion dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cypher_key   (key),
        .o_expanded_key (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        logic       hi;
        p = 8'h00;
        x = a;
        y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y  = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box derived from GF(2^8) inversion plus the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] model(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key   = FIPS_KEY;
        step();
        checks++;
        if (out !== '0) begin
            failures++;
            $display("FAIL reset_zero got=%h exp=0", out[1407:1280]);
        end
        step();
        checks++;
        if (out !== '0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=0", out[1407:1280]);
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (out !== '0) begin
            failures++;
            $display("FAIL release_before_edge got=%h exp=0", out[1407:1280]);
        end
    endtask

    task automatic test_fips();
        step();
        checks++;
        if (out[1407:1280] !== FIPS_KEY) begin
            failures++;
            $display("FAIL fips_rk0 got=%h exp=%h", out[1407:1280], FIPS_KEY);
        end
        checks++;
        if (out[1407-32*4 -: 32] !== 32'ha0fafe17) begin
            failures++;
            $display("FAIL fips_w4 got=%h exp=a0fafe17", out[1407-32*4 -: 32]);
        end
        checks++;
        if (out[1407-32*7 -: 32] !== 32'h2a6c7605) begin
            failures++;
            $display("FAIL fips_w7 got=%h exp=2a6c7605", out[1407-32*7 -: 32]);
        end
        checks++;
        if (out[1407-128 -: 128] !== FIPS_RK1) begin
            failures++;
            $display("FAIL fips_rk1 got=%h exp=%h", out[1407-128 -: 128], FIPS_RK1);
        end
        checks++;
        if (out[127:0] !== FIPS_RK10) begin
            failures++;
            $display("FAIL fips_rk10 got=%h exp=%h", out[127:0], FIPS_RK10);
        end
    endtask

    task automatic test_back_to_back();
        logic [1407:0] exp_zero;
        logic [1407:0] exp_fips;
        exp_zero = model(ZERO_KEY);
        exp_fips = model(FIPS_KEY);
        key = ZERO_KEY;
        step();
        checks++;
        if (out[1407-128 -: 128] !== ZERO_RK1) begin
            failures++;
            $display("FAIL zero_rk1 got=%h exp=%h", out[1407-128 -: 128], ZERO_RK1);
        end
        checks++;
        if (out[127:0] !== ZERO_RK10) begin
            failures++;
            $display("FAIL zero_rk10 got=%h exp=%h", out[127:0], ZERO_RK10);
        end
        checks++;
        if (out !== exp_zero) begin
            failures++;
            $display("FAIL zero_full got=%h exp=%h", out[255:0], exp_zero[255:0]);
        end
        key = FIPS_KEY;
        step();
        checks++;
        if (out !== exp_fips) begin
            failures++;
            $display("FAIL b2b_fips_full got=%h exp=%h", out[255:0], exp_fips[255:0]);
        end
        key = ZERO_KEY;
        step();
        checks++;
        if (out !== exp_zero) begin
            failures++;
            $display("FAIL b2b_zero_again got=%h exp=%h", out[255:0], exp_zero[255:0]);
        end
    endtask

    task automatic test_mid_reset();
        key = FIPS_KEY;
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if (out !== '0) begin
            failures++;
            $display("FAIL mid_reset_zero got=%h exp=0", out[1407:1280]);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (out[127:0] !== FIPS_RK10 || out[1407:1280] !== FIPS_KEY) begin
            failures++;
            $display("FAIL mid_reset_recover got=%h exp=%h", out[127:0], FIPS_RK10);
        end
    endtask

    task automatic test_random();
        logic [1407:0] exp;
        int            bad;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            exp = model(key);
            step();
            checks++;
            if (out !== exp) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_%0d key=%h got=%h exp=%h", n, key, out[127:0], exp[127:0]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        key      = '0;
        build_sbox();
        test_reset();
        test_fips();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
